// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC and runs the imem request/response handshake
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic        pc_update,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_raw,
   output logic [31:0] pc,
   output logic        fetch_done,
   output logic        fetch_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fsm_t;

   localparam logic [2:0] ST_FETCH = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd4;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   fsm_t       fsm;
   logic [7:0] cnt;
   // Set whenever the core is outside FETCH; allows one fetch per FETCH visit.
   logic       armed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm        <= IDLE;
         cnt        <= 8'd0;
         armed      <= 1'b1;
         pc         <= RESET_PC;
         instr_raw  <= NOP_INSTR;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         if (state != ST_FETCH)
            armed <= 1'b1;

         // PC commit is independent of the FSM; imem_addr keeps its own copy.
         if (pc_update && state == ST_WRITE) begin
            if (branch_taken) begin
               pc <= {branch_target[31:2], 2'b00};
               if (branch_target[1:0] != 2'b00)
                  fetch_err <= 1'b1;
            end else begin
               pc <= pc + 32'd4;
            end
         end

         case (fsm)
            IDLE: begin
               if (state == ST_FETCH && armed) begin
                  fsm       <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
                  busy      <= 1'b1;
                  armed     <= 1'b0;
               end
            end
            REQ: begin
               if (imem_ready) begin
                  imem_req <= 1'b0;
                  cnt      <= 8'd0;
                  if (imem_valid) begin
                     instr_raw  <= imem_rdata;
                     fetch_done <= 1'b1;
                     fsm        <= DONE;
                  end else begin
                     fsm <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (imem_valid) begin
                  instr_raw  <= imem_rdata;
                  fetch_done <= 1'b1;
                  fsm        <= DONE;
               end else if (cnt == CNT_LAST) begin
                  instr_raw  <= NOP_INSTR;
                  fetch_err  <= 1'b1;
                  fetch_done <= 1'b1;
                  fsm        <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               fsm  <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with an architectural PC/instr/err model
module tb_fetch_unit;
   localparam int          TO  = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  state = 3'd1;
   logic        pc_update = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_ready = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr_raw;
   logic [31:0] pc;
   logic        fetch_done;
   logic        fetch_err;
   logic        busy;

   fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .state(state), .pc_update(pc_update),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_raw(instr_raw),
      .pc(pc), .fetch_done(fetch_done), .fetch_err(fetch_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc = RPC;
   logic [31:0] m_instr = NOP;
   logic        m_err = 1'b0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural model: PC and sticky error follow the commit rules directly.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc    = RPC;
         m_err   = 1'b0;
         m_instr = NOP;
      end else if (pc_update && state == 3'd4) begin
         if (branch_taken) begin
            m_pc = {branch_target[31:2], 2'b00};
            if (branch_target[1:0] != 2'b00) m_err = 1'b1;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst) begin
         check("pc", pc, m_pc);
         check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
         check("instr_raw", instr_raw, m_instr);
      end
   end

   task automatic pc_upd(input logic t, input logic [31:0] tgt, input logic [2:0] st);
      @(posedge clk); #1;
      state = st; pc_update = 1'b1; branch_taken = t; branch_target = tgt;
      @(posedge clk); #1;
      pc_update = 1'b0; branch_taken = 1'b0; state = 3'd1;
   endtask

   // Memory responder: holds ready low rdy_lo cycles, returns valid vlat cycles after
   // acceptance (0 = same cycle as ready, negative = never).
   task automatic do_fetch(input string tag, input int rdy_lo, input int vlat,
                           input logic [31:0] word, input logic [31:0] exp_addr, input int exp_lat);
      int a = -1;
      int lo = 0;
      int dones = 0;
      int lat = -1;
      int req_cyc = 0;
      int addr_bad = 0;
      int extra_req = 0;
      bit to_exp;
      to_exp = (vlat < 0);
      @(posedge clk); #1;
      state = 3'd0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         imem_ready = 1'b0;
         imem_valid = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         if (k == exp_lat - 1) begin
            m_instr = to_exp ? NOP : word;
            if (to_exp) m_err = 1'b1;
         end
         if (fetch_done) begin
            dones++;
            if (lat < 0) lat = k + 1;
         end
         if (imem_req) begin
            req_cyc++;
            if (lat >= 0) extra_req++;
            if (imem_addr !== exp_addr) addr_bad++;
         end
         if (lat >= 0) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hBAD0_0BAD;
         end else if (imem_req && a < 0) begin
            if (lo < rdy_lo) begin
               lo++;
            end else begin
               imem_ready = 1'b1;
               a = k + 1;
               if (vlat == 0) begin
                  imem_valid = 1'b1;
                  imem_rdata = word;
               end
            end
         end else if (a >= 0 && vlat > 0 && k + 1 == a + vlat) begin
            imem_valid = 1'b1;
            imem_rdata = word;
         end
         if (lat >= 0 && k >= lat + 3) break;
      end
      @(posedge clk); #1;
      imem_valid = 1'b0;
      imem_ready = 1'b0;
      state = 3'd1;
      check({tag, " done_count"}, 32'(dones), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " req_cycles"}, 32'(req_cyc), 32'(rdy_lo + 1));
      check({tag, " addr_bad"}, 32'(addr_bad), 32'd0);
      check({tag, " refetch"}, 32'(extra_req), 32'd0);
      check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst imem_req", {31'd0, imem_req}, 32'd0);
      check("rst imem_addr", imem_addr, RPC);
      check("rst instr_raw", instr_raw, NOP);
      check("rst pc", pc, RPC);
      check("rst fetch_done", {31'd0, fetch_done}, 32'd0);
      check("rst fetch_err", {31'd0, fetch_err}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;

      do_fetch("first", 0, 1, 32'h0050_0093, 32'h0, 3);
      check("first instr", instr_raw, 32'h0050_0093);
      check("first pc", pc, 32'h0);

      for (int i = 1; i <= 3; i++) begin
         pc_upd(1'b0, 32'd0, 3'd4);
         check("seq pc", pc, 32'(i * 4));
         do_fetch("seq", 0, 1, 32'h0000_1000 + 32'(i), 32'(i * 4), 3);
      end

      do_fetch("backpressure", 5, 1, 32'h00A0_0113, 32'hC, 8);
      check("bp instr", instr_raw, 32'h00A0_0113);

      pc_upd(1'b1, 32'h0000_0500, 3'd2);
      check("update outside write", pc, 32'hC);

      do_fetch("same_cycle", 0, 0, 32'h0020_8193, 32'hC, 2);

      pc_upd(1'b1, 32'h0000_0200, 3'd4);
      check("branch aligned pc", pc, 32'h200);
      check("branch aligned err", {31'd0, fetch_err}, 32'd0);
      pc_upd(1'b1, 32'h0000_0102, 3'd4);
      check("branch misaligned pc", pc, 32'h100);
      check("branch misaligned err", {31'd0, fetch_err}, 32'd1);

      // Asynchronous reset while the fetch waits for data.
      @(posedge clk); #1;
      state = 3'd0;
      @(posedge clk); #1;
      imem_ready = 1'b1;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      @(posedge clk); #1;
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      #2;
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check("async imem_req", {31'd0, imem_req}, 32'd0);
      check("async busy", {31'd0, busy}, 32'd0);
      check("async pc", pc, RPC);
      check("async fetch_err", {31'd0, fetch_err}, 32'd0);
      check("async fetch_done", {31'd0, fetch_done}, 32'd0);
      state = 3'd1;
      @(posedge clk); #1;
      rst = 1'b1;
      chk_en = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      imem_valid = 1'b0;
      check("stray valid instr", instr_raw, NOP);
      check("stray valid done", {31'd0, fetch_done}, 32'd0);

      do_fetch("timeout", 0, -1, 32'h0, RPC, TO + 2);
      check("timeout instr", instr_raw, 32'h0000_0013);
      check("timeout err", {31'd0, fetch_err}, 32'd1);

      pc_upd(1'b1, 32'hFFFF_FFFC, 3'd4);
      check("pre-wrap pc", pc, 32'hFFFF_FFFC);
      pc_upd(1'b0, 32'd0, 3'd4);
      check("wrap pc", pc, 32'h0);
      do_fetch("wrap", 0, 1, 32'h0000_0033, 32'h0, 3);

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
